// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures the period and high time of a divided clock
// (i_meas_clk) in i_ref_clk cycles and checks the period against an expected
// ratio. It reports lock, per-capture mismatch and a sticky timeout.
// Optional duty check: define CLK_RATIO_METER_DUTY_CHECK_EN so that the high
// count must also equal floor(expected/2); o_duty_err is tied 0 otherwise.
// Outputs are valid-only: o_valid is a 1-cycle strobe with no ready/backpressure.
// o_ratio and o_high_cnt are stable from one o_valid to the next, and
// o_mismatch/o_duty_err are only ever high together with o_valid.
module clk_ratio_meter #(
  parameter int RATIO_W     = 8,
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_meas_clk,
  input  logic               i_enable,
  input  logic [RATIO_W-1:0] i_expected_ratio,
  output logic [CNT_W-1:0]   o_ratio,
  output logic [CNT_W-1:0]   o_high_cnt,
  output logic               o_valid,
  output logic               o_mismatch,
  output logic               o_locked,
  output logic               o_timeout,
  output logic               o_duty_err,
  output logic [1:0]         o_dbg_state
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_e;

  state_e              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                s_d_q;
  logic [CNT_W-1:0]    period_cnt_q;
  logic [CNT_W-1:0]    high_cnt_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic [CNT_W-1:0]    ratio_q;
  logic [CNT_W-1:0]    high_res_q;
  logic                valid_q;
  logic                mismatch_q;
  logic                locked_q;
  logic                timeout_q;
  logic                duty_err_q;

  logic                s;
  logic                edge_det;
  logic [CNT_W-1:0]    exp_ext;
  logic                check_en;
  logic                period_ok;
  logic                match;
  logic                duty_fail;
  logic [CNT_W-1:0]    period_inc_d;
  logic [CNT_W-1:0]    high_inc_d;
  logic [LOCK_W-1:0]   lock_inc_d;
  logic                timed_out;

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~s_d_q;

  // Synchronize the measured clock and keep its previous value for edge detection.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_meas_clk};
      s_d_q  <= s;
    end
  end

  // Compare of the in-flight count against the expected ratio (ratio 0/1 disables checking).
  always_comb begin
    exp_ext      = {{(CNT_W-RATIO_W){1'b0}}, i_expected_ratio};
    check_en     = |i_expected_ratio[RATIO_W-1:1];
    period_ok    = (period_cnt_q == exp_ext);
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
    match        = period_ok && (high_cnt_q == (exp_ext >> 1));
    duty_fail    = period_ok && (high_cnt_q != (exp_ext >> 1));
`else
    match        = period_ok;
    duty_fail    = 1'b0;
`endif
    period_inc_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + 1'b1;
    high_inc_d   = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + CNT_W'(s);
    lock_inc_d   = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
    timed_out    = (period_cnt_q >= TIMEOUT_C);
  end

  // Measurement FSM: discard the first partial period, then capture every full one.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      ratio_q      <= '0;
      high_res_q   <= '0;
      valid_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      duty_err_q   <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      duty_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          period_cnt_q <= '0;
          high_cnt_q   <= '0;
          lock_cnt_q   <= '0;
          locked_q     <= 1'b0;
          if (i_enable) state_q <= ST_WAIT_EDGE;
        end
        ST_WAIT_EDGE: begin
          if (!i_enable) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            locked_q     <= 1'b0;
          end else if (edge_det) begin
            period_cnt_q <= CNT_W'(1);
            high_cnt_q   <= CNT_W'(1);
            state_q      <= ST_MEASURE;
          end else if (timed_out) begin
            timeout_q    <= 1'b1;
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
            period_cnt_q <= '0;
          end else begin
            period_cnt_q <= period_inc_d;
          end
        end
        ST_MEASURE: begin
          if (!i_enable) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            locked_q     <= 1'b0;
          end else if (edge_det) begin
            ratio_q      <= period_cnt_q;
            high_res_q   <= high_cnt_q;
            valid_q      <= 1'b1;
            timeout_q    <= 1'b0;
            period_cnt_q <= CNT_W'(1);
            high_cnt_q   <= CNT_W'(1);
            if (!check_en) begin
              lock_cnt_q <= '0;
              locked_q   <= 1'b0;
            end else if (match) begin
              lock_cnt_q <= lock_inc_d;
              locked_q   <= (lock_inc_d == LOCK_MAX);
            end else begin
              mismatch_q <= 1'b1;
              duty_err_q <= duty_fail;
              lock_cnt_q <= '0;
              locked_q   <= 1'b0;
            end
          end else if (timed_out) begin
            timeout_q    <= 1'b1;
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            state_q      <= ST_WAIT_EDGE;
          end else begin
            period_cnt_q <= period_inc_d;
            high_cnt_q   <= high_inc_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ratio     = ratio_q;
  assign o_high_cnt  = high_res_q;
  assign o_valid     = valid_q;
  assign o_mismatch  = mismatch_q;
  assign o_locked    = locked_q;
  assign o_timeout   = timeout_q;
  assign o_duty_err  = duty_err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter. A ref-derived divider model drives
// i_meas_clk; divider changes take effect at a period boundary so every full
// period seen by the meter is clean.
module tb_clk_ratio_meter;

  localparam int RATIO_W = 8;
  localparam int CNT_W   = 10;

  logic               clk;
  logic               rst_n;
  logic               meas_clk;
  logic               enable;
  logic [RATIO_W-1:0] expected;
  logic [CNT_W-1:0]   ratio;
  logic [CNT_W-1:0]   high_cnt;
  logic               valid;
  logic               mismatch;
  logic               locked;
  logic               timeout;
  logic               duty_err;
  logic [1:0]         dbg_state;

  int n_vec;
  int n_err;
  logic got;

  // divider model state
  int div_n, high_n, pend_div, pend_high, phase;
  logic run_meas;

  clk_ratio_meter #(
    .RATIO_W(RATIO_W), .CNT_W(CNT_W), .SYNC_STAGES(2),
    .LOCK_COUNT(4), .TIMEOUT(20)
  ) dut (
    .i_ref_clk(clk), .i_rst_n(rst_n), .i_meas_clk(meas_clk),
    .i_enable(enable), .i_expected_ratio(expected),
    .o_ratio(ratio), .o_high_cnt(high_cnt), .o_valid(valid),
    .o_mismatch(mismatch), .o_locked(locked), .o_timeout(timeout),
    .o_duty_err(duty_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // divider model: one ref-cycle step per posedge, driven 1 time unit later
  initial begin
    meas_clk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!run_meas) begin
        meas_clk = 1'b0;
      end else begin
        phase = phase + 1;
        if (phase >= div_n) begin
          phase  = 0;
          div_n  = pend_div;
          high_n = pend_high;
        end
        meas_clk = (phase < high_n);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int d, input int h);
    pend_div  = d;
    pend_high = h;
  endtask

  // wait (bounded) for the next o_valid, sampled on the falling edge
  task automatic wait_valid();
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_val("valid_wait", 0, 1);
  endtask

  // skip captures until one reports the target ratio (bounded)
  task automatic wait_ratio(input int target);
    for (int k = 0; k < 8; k++) begin
      wait_valid();
      if (!got || ratio == CNT_W'(target)) break;
    end
    check_val("ratio_reached", {31'd0, got && (ratio == CNT_W'(target))}, 1);
  endtask

  initial begin
    int cyc;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; enable = 1'b0; expected = 8'd4;
    div_n = 4; high_n = 2; pend_div = 4; pend_high = 2; phase = 0;
    run_meas = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check_val("rst_ratio", 32'(ratio), 0);
    check_val("rst_high", 32'(high_cnt), 0);
    check_val("rst_valid", 32'(valid), 0);
    check_val("rst_locked", 32'(locked), 0);
    check_val("rst_timeout", 32'(timeout), 0);
    check_val("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ratio 4 / expected 4: lock on the 4th capture
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wait_valid();
      check_val("r4_ratio", 32'(ratio), 4);
      check_val("r4_high", 32'(high_cnt), 2);
      check_val("r4_mismatch", 32'(mismatch), 0);
      check_val("r4_locked", 32'(locked), (k >= 4) ? 1 : 0);
    end

    // disable for 5 cycles: lock drops next cycle, result holds
    enable = 1'b0;
    div_n = 6; high_n = 3; pend_div = 6; pend_high = 3; phase = 0;
    expected = 8'd6;
    @(negedge clk);
    check_val("dis_locked", 32'(locked), 0);
    check_val("dis_ratio", 32'(ratio), 4);
    check_val("dis_state", 32'(dbg_state), 0);
    repeat (4) @(negedge clk);
    check_val("dis_valid", 32'(valid), 0);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_valid();
      check_val("r6_ratio", 32'(ratio), 6);
      check_val("r6_high", 32'(high_cnt), 3);
      check_val("r6_locked", 32'(locked), (k == 4) ? 1 : 0);
    end

    // divider moves to 5 with expected still 6
    set_div(5, 2);
    wait_ratio(5);
    check_val("r5_mismatch", 32'(mismatch), 1);
    check_val("r5_locked", 32'(locked), 0);
    check_val("r5_high", 32'(high_cnt), 2);
    wait_valid();
    check_val("r5_ratio2", 32'(ratio), 5);
    check_val("r5_mismatch2", 32'(mismatch), 1);

    // expected 1 means no checking
    expected = 8'd1;
    set_div(2, 1);
    wait_ratio(2);
    for (int k = 0; k < 5; k++) begin
      wait_valid();
      check_val("e1_ratio", 32'(ratio), 2);
      check_val("e1_high", 32'(high_cnt), 1);
      check_val("e1_mismatch", 32'(mismatch), 0);
      check_val("e1_locked", 32'(locked), 0);
    end

    // lock at ratio 2, then stop the clock for timeout
    expected = 8'd2;
    for (int k = 1; k <= 5; k++) wait_valid();
    check_val("r2_locked", 32'(locked), 1);
    run_meas = 1'b0;
    cyc = 0;
    while (!timeout && cyc < 100) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    check_val("to_flag", 32'(timeout), 1);
    check_val("to_window", {31'd0, (cyc >= 15 && cyc <= 30)}, 1);
    check_val("to_locked", 32'(locked), 0);
    repeat (10) @(negedge clk);
    check_val("to_sticky", 32'(timeout), 1);
    run_meas = 1'b1;
    wait_valid();
    check_val("to_clear", 32'(timeout), 0);
    check_val("to_ratio", 32'(ratio), 2);

    // period 8 with 3 high cycles, expected 8
    expected = 8'd8;
    set_div(8, 3);
    wait_ratio(8);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) wait_valid();
      check_val("d8_ratio", 32'(ratio), 8);
      check_val("d8_high", 32'(high_cnt), 3);
`ifdef CLK_RATIO_METER_DUTY_CHECK_EN
      check_val("d8_duty_err", 32'(duty_err), 1);
      check_val("d8_mismatch", 32'(mismatch), 1);
      check_val("d8_locked", 32'(locked), 0);
`else
      check_val("d8_duty_err", 32'(duty_err), 0);
      check_val("d8_mismatch", 32'(mismatch), 0);
      check_val("d8_locked", 32'(locked), (k == 4) ? 1 : 0);
`endif
    end

    // reset mid-period clears everything immediately
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_ratio", 32'(ratio), 0);
    check_val("mid_rst_locked", 32'(locked), 0);
    check_val("mid_rst_state", 32'(dbg_state), 0);
    repeat (5) @(negedge clk);
    check_val("mid_rst_valid", 32'(valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
Receive-side companion to the team's configurable clock divider. It samples a divided clock that is asynchronous to `i_ref_clk`, or derived from it, and measures its period and high time in `i_ref_clk` cycles. It compares the measured period against an expected ratio and reports lock, mismatch and timeout. It sits beside each divided-clock domain as a health monitor for the system controller.

Parameters:
- `RATIO_W`, default 8: width of the expected-ratio input.
- `CNT_W`, default 10: width of the period/high counters and of the result outputs. Must satisfy `CNT_W > RATIO_W`.
- `SYNC_STAGES`, default 2: flops in the `i_meas_clk` synchronizer. Minimum 2.
- `LOCK_COUNT`, default 4: consecutive matching periods required to assert `o_locked`. Must be ≥ 1.
- `TIMEOUT`, default 1000: ref cycles without a rising edge before timeout. Must be < 2**CNT_W.

Ports:
- `i_ref_clk`, in, 1: reference clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_meas_clk`, in, 1: divided clock under measurement; asynchronous.
- `i_enable`, in, 1: measurement enable.
- `i_expected_ratio`, in, RATIO_W: expected period in ref cycles.
- `o_ratio`, out, CNT_W: last measured period.
- `o_high_cnt`, out, CNT_W: last measured high time.
- `o_valid`, out, 1: 1-cycle pulse; new `o_ratio`/`o_high_cnt` present.
- `o_mismatch`, out, 1: 1-cycle pulse with `o_valid` when the result does not match the expected ratio.
- `o_locked`, out, 1: level; the measured clock matches expectation.
- `o_timeout`, out, 1: sticky level; no edge within `TIMEOUT`.
- `o_duty_err`, out, 1: see Optional Feature.

Behaviour:
- Reset is `i_rst_n`, asynchronous, active-low; clock is `i_ref_clk`. All outputs, counters and sync flops go to 0; FSM goes to IDLE.
- Synchronizer: `i_meas_clk` passes through `SYNC_STAGES` flops giving `s`. A previous-value flop gives `s_d`. `edge = s & ~s_d`.
- FSM states:
  - IDLE: counters cleared, `o_locked` = 0. Moves to WAIT_EDGE when `i_enable` = 1.
  - WAIT_EDGE: discards the partial first period. `period_cnt` increments, saturating. On `edge`: `period_cnt` <= 1, `high_cnt` <= 1, go to MEASURE.
  - MEASURE: each cycle without an edge, `period_cnt` +1, and `high_cnt` +1 if `s` = 1. On `edge` (a capture):
    - `o_ratio` <= `period_cnt`; `o_high_cnt` <= `high_cnt`; `o_valid` <= 1.
    - Both counters reload to 1; stay in MEASURE.
- Result: a divide-by-N clock from `ClkDiv` fed in gives `o_ratio` = N and `o_high_cnt` = floor(N/2).
- Latency: `o_valid` is asserted on the cycle after the `edge` cycle. `edge` occurs `SYNC_STAGES`+1 ref cycles after the `i_meas_clk` rise. Results are stable until the next capture.
- Compare: match means `o_ratio` == zero-extended `i_expected_ratio`, sampled on the capture cycle.
  - Match: `lock_cnt` +1, saturating at `LOCK_COUNT`. `o_locked` = (`lock_cnt` == `LOCK_COUNT`), registered; it rises with the `LOCK_COUNT`-th matching `o_valid`.
  - Mismatch: `o_mismatch` pulses with `o_valid`, `lock_cnt` <= 0 and `o_locked` <= 0 on the same cycle.
- Expected ratio 0 or 1: no check is made. `o_mismatch` = 0, `lock_cnt` is held at 0, `o_locked` = 0. Measurement still runs.
- Timeout: in WAIT_EDGE or MEASURE, if `period_cnt` reaches `TIMEOUT` with no edge:
  - `o_timeout` <= 1; `o_locked` <= 0; `lock_cnt` <= 0.
  - State goes to WAIT_EDGE and `period_cnt` <= 0.
  - `o_timeout` clears on the next `o_valid`.
- Edge coincident with timeout: the edge wins and no timeout is flagged.
- `i_enable` falling mid-operation: go to IDLE next cycle; counters, `lock_cnt` and `o_locked` clear; `o_valid` = 0. `o_ratio`/`o_high_cnt`/`o_timeout` hold their values.
- Re-enable: the first partial period is always discarded.
- Changing `i_expected_ratio` does not by itself clear lock; the next capture is compared against the new value.
- Reset mid-period: immediate clear; no `o_valid` is produced.

Optional Feature:
- Macro: `CLK_RATIO_METER_DUTY_CHECK_EN`.
- Defined: a capture is a match only if `o_ratio` == expected AND `o_high_cnt` == floor(`i_expected_ratio`/2).
  - `o_duty_err` pulses with `o_valid` when the period matches but the high count does not.
  - `o_mismatch` also pulses in that case, and lock is cleared.
- Undefined: `o_duty_err` is tied 0 and the high count does not affect the compare or lock. `o_high_cnt` is still reported.

Test Plan:
- Drive `ClkDiv` ratio 4 → meter, expected = 4, `LOCK_COUNT` = 4 → every `o_valid` shows `o_ratio` = 4, `o_high_cnt` = 2. `o_locked` rises on the 4th `o_valid`; `o_mismatch` never fires.
- Locked at ratio 6, switch divider to ratio 5 with expected still 6 → first capture of period 5 gives `o_mismatch` pulse, `o_locked` falls the same cycle. Captures settle to `o_ratio` = 5.
- Hold `i_meas_clk` = 0 with `TIMEOUT` = 20 → `o_timeout` = 1 about 20 cycles after the last edge and `o_locked` = 0. Resuming the clock gives `o_timeout` = 0 on the first subsequent `o_valid`.
- Locked at ratio 3, deassert `i_enable` for 5 cycles and reassert → `o_locked` = 0 next cycle, `o_ratio` holds 3. Relock requires `LOCK_COUNT` matches after one discarded partial period.
- Expected = 1 with divider ratio 2 → `o_ratio` = 2 reported, `o_mismatch` = 0, `o_locked` stays 0.
- Macro defined, async 50%-duty input replaced by a period-8 clock with 3 high cycles, expected = 8 → `o_duty_err` and `o_mismatch` pulse and `o_locked` stays 0. Without the macro → `o_locked` after 4 captures.
